uart_tx_arbiter: RTL

- Shares the single UART transmitter between two byte-stream requesters, e.g. the measurement reporter and the command echo/status path.
- Arbitration is round-robin with packet lock: a granted requester keeps the transmitter until its byte flagged last has been sent.
- The block sequences the UART's transmit/tx_byte/is_transmitting handshake, watches for stalls, and reports errors.
- It sits between the requesters and the uart instance inside top.

---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte-stream requesters.
// A packet holds the grant until its last byte is sent; start stalls and lock stalls set sticky errors.
module uart_tx_arbiter #(
    parameter int unsigned pStartTimeout = 16,
    parameter int unsigned pLockTimeout  = 480000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic       uart_transmit_o,
    output logic [7:0] uart_tx_byte_o,
    input  logic       uart_is_transmitting_i,
    output logic       owner_o,
    output logic       locked_o,
    output logic       busy_o,
    output logic       err_start_to_o,
    output logic       err_lock_to_o,
    input  logic       err_clr_i
);

    localparam int unsigned StartW = $clog2(pStartTimeout + 1);
    localparam int unsigned LockW  = $clog2(pLockTimeout + 1);
    localparam logic [StartW-1:0] StartMax = StartW'(pStartTimeout - 1);
    localparam logic [LockW-1:0]  LockMax  = LockW'(pLockTimeout - 1);

    typedef enum logic [1:0] {StIdle, StWaitStart, StWaitDone} state_e;

    state_e              state_q;
    logic                owner_q;
    logic                locked_q;
    logic                rr_q;
    logic                tx_q;
    logic [7:0]          tx_byte_q;
    logic                err_start_q;
    logic                err_lock_q;
    logic [StartW-1:0]   start_cnt_q;
    logic [LockW-1:0]    lock_cnt_q;

    logic       sel;
    logic       any_eligible;
    logic       take;
    logic       owner_valid;
    logic [7:0] sel_data;
    logic       sel_last;

    always_comb begin
        sel          = 1'b0;
        any_eligible = 1'b0;
        owner_valid  = owner_q ? req1_valid_i : req0_valid_i;
        if (locked_q) begin
            sel          = owner_q;
            any_eligible = owner_valid;
        end else if (req0_valid_i && req1_valid_i) begin
            sel          = rr_q;
            any_eligible = 1'b1;
        end else begin
            sel          = req1_valid_i;
            any_eligible = req0_valid_i | req1_valid_i;
        end
        take         = (state_q == StIdle) && any_eligible;
        req0_ready_o = take && !sel;
        req1_ready_o = take && sel;
        sel_data     = sel ? req1_data_i : req0_data_i;
        sel_last     = sel ? req1_last_i : req0_last_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            locked_q    <= 1'b0;
            rr_q        <= 1'b0;
            tx_q        <= 1'b0;
            tx_byte_q   <= 8'h00;
            err_start_q <= 1'b0;
            err_lock_q  <= 1'b0;
            start_cnt_q <= '0;
            lock_cnt_q  <= '0;
        end else begin
            tx_q <= 1'b0;
            // Clear first so an error raised on the same edge overrides it.
            if (err_clr_i) begin
                err_start_q <= 1'b0;
                err_lock_q  <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (take) begin
                        tx_byte_q   <= sel_data;
                        tx_q        <= 1'b1;
                        owner_q     <= sel;
                        rr_q        <= ~sel;
                        locked_q    <= ~sel_last;
                        start_cnt_q <= '0;
                        lock_cnt_q  <= '0;
                        state_q     <= StWaitStart;
                    end else if (locked_q && !owner_valid) begin
                        if (lock_cnt_q == LockMax) begin
                            locked_q   <= 1'b0;
                            err_lock_q <= 1'b1;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 1'b1;
                        end
                    end
                end
                StWaitStart: begin
                    if (uart_is_transmitting_i) begin
                        state_q <= StWaitDone;
                    end else if (start_cnt_q == StartMax) begin
                        // Byte is dropped; the requester already saw its ready.
                        err_start_q <= 1'b1;
                        locked_q    <= 1'b0;
                        start_cnt_q <= '0;
                        state_q     <= StIdle;
                    end else begin
                        start_cnt_q <= start_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!uart_is_transmitting_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uart_transmit_o = tx_q;
    assign uart_tx_byte_o  = tx_byte_q;
    assign owner_o         = owner_q;
    assign locked_o        = locked_q;
    assign busy_o          = (state_q != StIdle);
    assign err_start_to_o  = err_start_q;
    assign err_lock_to_o   = err_lock_q;

endmodule
